// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// FSM states and operation classes.
package muldiv_pkg;

   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MTHI = 6'b010001;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MTLO = 6'b010011;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV = 6'b011010;
   localparam logic [5:0] F_DIVU = 6'b011011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX = 2'd2
   } state_e;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_e;

   // True for every funct this unit owns (move and iterative groups).
   function automatic logic f_in_group(input logic [5:0] funct);
      case (funct[5:2])
         4'b0100: f_in_group = 1'b1;
         4'b0110: f_in_group = 1'b1;
         default: f_in_group = 1'b0;
      endcase
   endfunction

   function automatic logic f_is_iter(input logic [5:0] funct);
      case (funct[5:2])
         4'b0110: f_is_iter = 1'b1;
         default: f_is_iter = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: shift-add multiply / restoring divide on operand
// magnitudes, iteration counter, and final sign fixup.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_div,
   input  logic             i_sgn,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_step,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]   r_srca;
   logic [CNT_W-1:0]   r_cnt;
   op_e                r_op;
   logic               r_neg;
   logic               r_rneg;
   logic               r_dz;

   logic [WIDTH:0]     w_madd;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_n;

   // Magnitude as an unsigned value; the most negative input maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic sgn);
      f_mag = (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   assign w_madd   = {1'b0, r_a} + {1'b0, (r_q[0] ? r_m : {WIDTH{1'b0}})};
   assign w_shift  = {r_a, r_q[WIDTH-1]};
   assign w_ge     = (w_shift >= {1'b0, r_m});
   assign w_diff   = w_shift - {1'b0, r_m};
   assign w_prod   = {r_a, r_q};
   assign w_prod_n = r_neg ? -w_prod : w_prod;
   assign o_last   = (r_cnt == CNT_W'(WIDTH - 1));

   // Operand capture on load, then one multiply/divide step per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a    <= {WIDTH{1'b0}};
         r_q    <= {WIDTH{1'b0}};
         r_m    <= {WIDTH{1'b0}};
         r_srca <= {WIDTH{1'b0}};
         r_cnt  <= {CNT_W{1'b0}};
         r_op   <= OP_MUL;
         r_neg  <= 1'b0;
         r_rneg <= 1'b0;
         r_dz   <= 1'b0;
      end else if (i_load) begin
         r_a    <= {WIDTH{1'b0}};
         r_q    <= f_mag(i_a, i_sgn);
         r_m    <= f_mag(i_b, i_sgn);
         r_srca <= i_a;
         r_cnt  <= {CNT_W{1'b0}};
         r_op   <= i_div ? OP_DIV : OP_MUL;
         r_neg  <= i_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         r_rneg <= i_sgn & i_a[WIDTH-1];
         r_dz   <= i_div & (i_b == {WIDTH{1'b0}});
      end else if (i_step) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_op == OP_MUL) begin
            r_a <= w_madd[WIDTH:1];
            r_q <= {w_madd[0], r_q[WIDTH-1:1]};
         end else begin
            r_a <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], w_ge};
         end
      end
   end

   // Sign fixup; divide-by-zero bypasses it and returns the raw dividend.
   always_comb begin
      o_hi = w_prod_n[2*WIDTH-1:WIDTH];
      o_lo = w_prod_n[WIDTH-1:0];
      case (r_op)
         OP_DIV: begin
            if (r_dz) begin
               o_lo = {WIDTH{1'b1}};
               o_hi = r_srca;
            end else begin
               o_lo = r_neg ? -r_q : r_q;
               o_hi = r_rneg ? -r_a : r_a;
            end
         end
         default: begin
            o_hi = w_prod_n[2*WIDTH-1:WIDTH];
            o_lo = w_prod_n[WIDTH-1:0];
         end
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: funct decode, IDLE/CALC/FIX control,
// HI/LO registers and busy/done/stall handshake.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);
   state_e           r_state;
   op_e              w_op;
   logic             w_sgn;
   logic             w_iter;
   logic             w_load;
   logic             w_last;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;

   assign w_iter = f_is_iter(funct);
   assign w_op   = (funct == F_DIV || funct == F_DIVU) ? OP_DIV : OP_MUL;
   assign w_sgn  = (funct == F_MULT || funct == F_DIV);
   assign w_load = start & w_iter & (r_state == IDLE);
   assign busy   = (r_state != IDLE);
   assign stall  = start & busy & f_in_group(funct);

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_div  (w_op == OP_DIV),
      .i_sgn  (w_sgn),
      .i_a    (srca),
      .i_b    (srcb),
      .i_step (r_state == CALC),
      .o_last (w_last),
      .o_hi   (w_res_hi),
      .o_lo   (w_res_lo)
   );

   // Control FSM with HI/LO writes and the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         hi      <= {WIDTH{1'b0}};
         lo      <= {WIDTH{1'b0}};
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (w_iter) begin
                     r_state <= CALC;
                  end else if (funct == F_MTHI) begin
                     hi <= srca;
                  end else if (funct == F_MTLO) begin
                     lo <= srca;
                  end
               end
            end
            CALC: begin
               if (w_last) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               hi      <= w_res_hi;
               lo      <= w_res_lo;
               done    <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of operations checked through a
// result scoreboard, plus hand sequences for stall, move and reset corners.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [5:0]   funct;
   logic [W-1:0] srca;
   logic [W-1:0] srcb;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         stall;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [5:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eh;
      logic [W-1:0] el;
   } vec_t;

   vec_t vecs[13];
   logic [2*W-1:0] sb[$];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .funct (funct),
      .srca  (srca),
      .srcb  (srcb),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done),
      .stall (stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
      @(negedge clk);
      start = 1'b1;
      funct = f;
      srca  = a;
      srcb  = b;
      sb.push_back({eh, el});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_op(input string nm, input int exp_busy);
      logic [2*W-1:0] e;
      int n;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (exp_busy >= 0) chk({nm, "_busy_cycles"}, 64'(n), 64'(exp_busy));
      chk({nm, "_done"}, {63'd0, done}, 64'd1);
      chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
         chk({nm, "_scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({nm, "_hilo"}, {hi, lo}, e);
      end
      @(negedge clk);
      chk({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      vecs[0]  = '{F_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2]  = '{F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[3]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{F_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
      vecs[5]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[6]  = '{F_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
      vecs[7]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[8]  = '{F_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
      vecs[9]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[10] = '{F_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
      vecs[11] = '{F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      vecs[12] = '{F_DIV,   32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000};

      reset = 1'b1;
      start = 1'b0;
      funct = 6'b000000;
      srca  = '0;
      srcb  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);

      // Non-group funct at IDLE changes nothing.
      @(negedge clk);
      start = 1'b1;
      funct = 6'b100000;
      srca  = 32'h0000BEEF;
      #1 chk("other_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      chk("other_busy", {63'd0, busy}, 64'd0);
      chk("other_hilo", {hi, lo}, 64'd0);

      // Moves at IDLE.
      @(negedge clk);
      start = 1'b1;
      funct = F_MTHI;
      srca  = 32'h00001234;
      @(negedge clk);
      chk("mthi_hi", {32'd0, hi}, 64'h1234);
      chk("mthi_done", {63'd0, done}, 64'd0);
      chk("mthi_busy", {63'd0, busy}, 64'd0);
      funct = F_MTLO;
      srca  = 32'h0000AAAA;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_lo", {32'd0, lo}, 64'hAAAA);
      chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234);

      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
         finish_op($sformatf("vec%0d", i), W + 1);
      end

      // Restore known HI/LO, then poke the unit while a multiply runs.
      @(negedge clk);
      start = 1'b1;
      funct = F_MTHI;
      srca  = 32'h00001234;
      @(negedge clk);
      funct = F_MTLO;
      srca  = 32'h0000AAAA;
      @(negedge clk);
      start = 1'b0;
      issue(F_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
      repeat (4) @(negedge clk);
      start = 1'b1;
      funct = F_MFLO;
      #1 chk("busy_mflo_stall", {63'd0, stall}, 64'd1);
      @(negedge clk);
      chk("busy_mflo_lo", {32'd0, lo}, 64'hAAAA);
      funct = F_MTHI;
      srca  = 32'h00005678;
      #1 chk("busy_mthi_stall", {63'd0, stall}, 64'd1);
      @(negedge clk);
      chk("busy_mthi_hi", {32'd0, hi}, 64'h1234);
      funct = 6'b100000;
      #1 chk("busy_other_stall", {63'd0, stall}, 64'd0);
      start = 1'b0;
      #1 chk("busy_nostart_stall", {63'd0, stall}, 64'd0);
      finish_op("busy_mult", -1);

      // Reset during the 10th CALC cycle discards the operation.
      @(negedge clk);
      start = 1'b1;
      funct = F_MULT;
      srca  = 32'h00000003;
      srcb  = 32'h00000005;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_busy", {63'd0, busy}, 64'd0);
      chk("midreset_done", {63'd0, done}, 64'd0);
      chk("midreset_hilo", {hi, lo}, 64'd0);
      issue(F_DIVU, 32'h00000009, 32'h00000004, 32'h00000001, 32'h00000002);
      finish_op("after_reset_divu", W + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
